// File: rtl/pool2x2_multi_pkg.sv
// Shared types and helpers for the multi-channel 2x2 pooling engine.
package pool_pkg;

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, WR, DONE} state_t;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Keeps the earlier operand on ties so the first-read tap wins.
    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/pool2x2_multi_if.sv
// Pixel-memory port shared with the convolution engine (1-cycle read latency).
interface pool2x2_multi_if #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_address_pix = 13
) ();
    logic        [SIZE_address_pix-1:0] read_addressp;
    logic                               re;
    logic signed [SIZE_1-1:0]           qp;
    logic        [SIZE_address_pix-1:0] write_addressp;
    logic                               we;
    logic signed [SIZE_1-1:0]           dp;

    modport master (output read_addressp, re, write_addressp, we, dp, input qp);
    modport slave  (input read_addressp, re, write_addressp, we, dp, output qp);
endinterface

// File: rtl/pool2x2_addr_gen.sv
// Window counters and address accumulators; produces the tap base B, the output
// address and a last-window flag using adders only.
module pool2x2_addr_gen #(
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_matrix      = 6,
    parameter int SIZE_ch          = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_adv,
    input  logic [SIZE_matrix-1:0]      i_n,
    input  logic [SIZE_ch-1:0]          i_c,
    input  logic [SIZE_address_pix-1:0] i_memstartp,
    input  logic [SIZE_address_pix-1:0] i_memstartzap,
    output logic [SIZE_address_pix-1:0] o_base,
    output logic [SIZE_address_pix-1:0] o_waddr,
    output logic                        o_last
);
    localparam int AW = SIZE_address_pix;
    localparam logic [AW-1:0] AddrOne = AW'(1);
    localparam logic [AW-1:0] AddrTwo = AW'(2);

    logic [SIZE_matrix-1:0] r_k, r_r, w_k_nxt, w_r_nxt, w_m_last;
    logic [SIZE_ch-1:0]     r_c, w_c_nxt;
    logic [AW-1:0]          r_row_base, r_base, r_waddr;
    logic [AW-1:0]          w_row_base_nxt, w_base_nxt, w_waddr_nxt;
    logic [AW-1:0]          w_n_ext, w_row_step, w_plane_step;
    logic                   w_k_last, w_r_last;

    assign w_m_last     = (i_n >> 1) - 1'b1;
    assign w_k_last     = (r_k == w_m_last);
    assign w_r_last     = (r_r == w_m_last);
    assign w_n_ext      = AW'(i_n);
    assign w_row_step   = w_n_ext << 1;
    // Jumping from the last window row to the next plane also skips a dropped odd row.
    assign w_plane_step = w_row_step + (i_n[0] ? w_n_ext : '0);

    always_comb begin
        w_k_nxt        = r_k;
        w_r_nxt        = r_r;
        w_c_nxt        = r_c;
        w_row_base_nxt = r_row_base;
        w_base_nxt     = r_base;
        w_waddr_nxt    = r_waddr;
        if (i_start) begin
            w_k_nxt        = '0;
            w_r_nxt        = '0;
            w_c_nxt        = '0;
            w_row_base_nxt = i_memstartp;
            w_base_nxt     = i_memstartp;
            w_waddr_nxt    = i_memstartzap;
        end else if (i_adv) begin
            w_waddr_nxt = r_waddr + AddrOne;
            if (!w_k_last) begin
                w_k_nxt    = r_k + 1'b1;
                w_base_nxt = r_base + AddrTwo;
            end else begin
                w_k_nxt = '0;
                if (!w_r_last) begin
                    w_r_nxt        = r_r + 1'b1;
                    w_row_base_nxt = r_row_base + w_row_step;
                end else begin
                    w_r_nxt        = '0;
                    w_c_nxt        = r_c + 1'b1;
                    w_row_base_nxt = r_row_base + w_plane_step;
                end
                w_base_nxt = w_row_base_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_r        <= '0;
            r_c        <= '0;
            r_row_base <= '0;
            r_base     <= '0;
            r_waddr    <= '0;
        end else begin
            r_k        <= w_k_nxt;
            r_r        <= w_r_nxt;
            r_c        <= w_c_nxt;
            r_row_base <= w_row_base_nxt;
            r_base     <= w_base_nxt;
            r_waddr    <= w_waddr_nxt;
        end
    end

    assign o_base  = r_base;
    assign o_waddr = r_waddr;
    assign o_last  = w_k_last && w_r_last && (r_c == i_c - 1'b1);

endmodule

// File: rtl/pool2x2_multi.sv
// Multi-channel 2x2 / stride-2 pooling engine (signed max or floor average)
// reading and writing through the shared pixel-memory port.
module pool2x2_multi
    import pool_pkg::*;
#(
    parameter int SIZE_1           = 11,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_matrix      = 6,
    parameter int SIZE_ch          = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        maxp_en,
    input  logic                        mode,
    input  logic [SIZE_matrix-1:0]      matrix,
    input  logic [SIZE_ch-1:0]          channels,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    pool2x2_multi_if.master             mem,
    output logic                        STOP
);
    localparam int AW    = SIZE_address_pix;
    localparam int ACC_W = SIZE_1 + 2;
    localparam logic [AW-1:0] AddrOne = AW'(1);

    state_t                   r_state, w_state_nxt;
    logic                     r_mode;
    logic [SIZE_matrix-1:0]   r_n;
    logic [SIZE_ch-1:0]       r_c;
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [ACC_W-1:0]  w_qp_ext, w_max, w_fold;
    logic signed [SIZE_1-1:0] w_avg, w_res;
    logic [AW-1:0]            w_base, w_waddr, w_n_addr, w_raddr, w_wraddr;
    logic                     w_last, w_start, w_re, w_we, w_stop;
    logic signed [SIZE_1-1:0] w_dp;

    assign w_start  = (r_state == IDLE) && maxp_en;
    assign w_n_addr = AW'(r_n);
    assign w_qp_ext = ACC_W'(mem.qp);
    assign w_max    = ACC_W'(smax(32'(r_acc), 32'(w_qp_ext)));
    assign w_fold   = (r_mode == POOL_AVG) ? (r_acc + w_qp_ext) : w_max;
    assign w_avg    = SIZE_1'(w_fold >>> 2);
    assign w_res    = (r_mode == POOL_AVG) ? w_avg : w_fold[SIZE_1-1:0];

    pool2x2_addr_gen #(
        .SIZE_address_pix(SIZE_address_pix),
        .SIZE_matrix     (SIZE_matrix),
        .SIZE_ch         (SIZE_ch)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_start),
        .i_adv        (w_we),
        .i_n          (r_n),
        .i_c          (r_c),
        .i_memstartp  (memstartp),
        .i_memstartzap(memstartzap),
        .o_base       (w_base),
        .o_waddr      (w_waddr),
        .o_last       (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (maxp_en) begin
                    w_state_nxt = (matrix < SIZE_matrix'(2) || channels == '0) ? DONE : T0;
                end
            end
            T0:      w_state_nxt = T1;
            T1:      w_state_nxt = T2;
            T2:      w_state_nxt = T3;
            T3:      w_state_nxt = WR;
            WR:      w_state_nxt = w_last ? DONE : T0;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
        // Dropping the enable abandons the run from any active state.
        if (r_state != IDLE && !maxp_en) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_re     = 1'b0;
        w_we     = 1'b0;
        w_stop   = 1'b0;
        w_raddr  = '0;
        w_wraddr = '0;
        w_dp     = '0;
        if (maxp_en) begin
            unique case (r_state)
                T0: begin w_re = 1'b1; w_raddr = w_base; end
                T1: begin w_re = 1'b1; w_raddr = w_base + AddrOne; end
                T2: begin w_re = 1'b1; w_raddr = w_base + w_n_addr; end
                T3: begin w_re = 1'b1; w_raddr = w_base + w_n_addr + AddrOne; end
                WR: begin
                    w_we     = 1'b1;
                    w_wraddr = w_waddr;
                    w_dp     = w_res;
                end
                DONE:    w_stop = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= POOL_MAX;
            r_n     <= '0;
            r_c     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_mode <= mode;
                r_n    <= matrix;
                r_c    <= channels;
            end
            if (r_state == T1) begin
                r_acc <= w_qp_ext;
            end else if (r_state == T2 || r_state == T3) begin
                r_acc <= w_fold;
            end
        end
    end

    assign mem.re             = w_re;
    assign mem.read_addressp  = w_raddr;
    assign mem.we             = w_we;
    assign mem.write_addressp = w_wraddr;
    assign mem.dp             = w_dp;
    assign STOP               = w_stop;

endmodule

// File: tb/tb_pool2x2_multi.sv
// Bench for pool2x2_multi: pixel-memory model, read/write scoreboard, table of
// edge-value runs and hand sequences for reset, abort and degenerate sizes.
module tb_pool2x2_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        maxp_en;
    logic        mode;
    logic [5:0]  matrix;
    logic [3:0]  channels;
    logic [12:0] memstartp;
    logic [12:0] memstartzap;
    logic        STOP;

    pool2x2_multi_if #(.SIZE_1(11), .SIZE_address_pix(13)) mem_if ();

    pool2x2_multi #(
        .SIZE_1          (11),
        .SIZE_address_pix(13),
        .SIZE_matrix     (6),
        .SIZE_ch         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .maxp_en    (maxp_en),
        .mode       (mode),
        .matrix     (matrix),
        .channels   (channels),
        .memstartp  (memstartp),
        .memstartzap(memstartzap),
        .mem        (mem_if),
        .STOP       (STOP)
    );

    always #5 clk = ~clk;

    logic signed [10:0] pmem [0:8191];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_if.qp <= '0;
        else if (mem_if.re) mem_if.qp <= pmem[mem_if.read_addressp];
    end

    typedef struct {
        logic [12:0]        a;
        logic signed [10:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [12:0] exp_rd[$];
    int          tests = 0;
    int          fails = 0;
    logic        sb_en = 1'b1;
    logic        stop_seen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got an access, expected none", name);
    endtask

    // Scoreboard: every read and write strobe is matched against the queues.
    always @(negedge clk) begin
        if (sb_en) begin
            if (mem_if.re) begin
                if (exp_rd.size() == 0) fail_now("rd_unexpected");
                else check("rd_addr", int'(mem_if.read_addressp), int'(exp_rd.pop_front()));
            end
            if (mem_if.we) begin
                if (exp_wr.size() == 0) fail_now("wr_unexpected");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", int'(mem_if.write_addressp), int'(e.a));
                    check("wr_data", int'(mem_if.dp), int'(e.d));
                end
            end
            if (STOP) stop_seen = 1'b1;
        end
    end

    task automatic push_model(input logic m, input int n, input int c, input int ps,
                              input int zs, input int rd_lim, input int wr_lim);
        int mm, nr, nw, b, res;
        int t [4];
        logic [12:0] a;
        wr_t e;
        mm = n / 2;
        nr = 0;
        nw = 0;
        for (int ch = 0; ch < c; ch++) begin
            for (int r = 0; r < mm; r++) begin
                for (int k = 0; k < mm; k++) begin
                    b = ps + ch * n * n + 2 * r * n + 2 * k;
                    for (int j = 0; j < 4; j++) begin
                        a = 13'(b + (j / 2) * n + (j % 2));
                        t[j] = int'(pmem[a]);
                        if (nr < rd_lim) begin
                            exp_rd.push_back(a);
                            nr++;
                        end
                    end
                    if (m) begin
                        res = (t[0] + t[1] + t[2] + t[3]) >>> 2;
                    end else begin
                        res = t[0];
                        for (int j = 1; j < 4; j++) if (t[j] > res) res = t[j];
                    end
                    if (nw < wr_lim) begin
                        e.a = 13'(zs + ch * mm * mm + r * mm + k);
                        e.d = 11'(res);
                        exp_wr.push_back(e);
                        nw++;
                    end
                end
            end
        end
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.a = 13'(a);
        e.d = 11'(d);
        exp_wr.push_back(e);
    endtask

    task automatic load4();
        int v [16] = '{1, 5, -3, 2, 7, 0, 4, -8, -1, -2, -6, -4, 9, 3, 2, 2};
        for (int i = 0; i < 16; i++) pmem[i] = 11'(v[i]);
    endtask

    // Starts a run, scrambles the sampled inputs one cycle later, and counts
    // clock edges until STOP rises (bounded).
    task automatic run(input logic m, input int n, input int c, input int ps, input int zs,
                       output int cyc);
        @(posedge clk); #1;
        mode        = m;
        matrix      = 6'(n);
        channels    = 4'(c);
        memstartp   = 13'(ps);
        memstartzap = 13'(zs);
        maxp_en     = 1'b1;
        stop_seen   = 1'b0;
        @(posedge clk); #1;
        mode     = ~m;
        matrix   = 6'd3;
        channels = 4'd1;
        cyc = 1;
        while (!STOP && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic end_run();
        repeat (3) begin @(posedge clk); #1; end
        check("stop_held", int'(STOP), 1);
        maxp_en = 1'b0;
        @(posedge clk); #1;
        check("stop_clear", int'(STOP), 0);
        check("rd_drain", exp_rd.size(), 0);
        check("wr_drain", exp_wr.size(), 0);
    endtask

    typedef struct {
        logic m;
        int   v;
        int   exp;
    } edge_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        edge_t tbl [6];
        int cyc, cnt;
        tbl[0] = '{1'b0, -1024, -1024};
        tbl[1] = '{1'b1,  1023,  1023};
        tbl[2] = '{1'b1, -1024, -1024};
        tbl[3] = '{1'b0,  1023,  1023};
        tbl[4] = '{1'b1,    -1,    -1};
        tbl[5] = '{1'b1,     0,     0};

        rst_n = 1'b0; maxp_en = 1'b0; mode = 1'b0; matrix = '0; channels = '0;
        memstartp = '0; memstartzap = '0;
        for (int i = 0; i < 8192; i++) pmem[i] = '0;
        #1;
        check("rst_re", int'(mem_if.re), 0);
        check("rst_we", int'(mem_if.we), 0);
        check("rst_stop", int'(STOP), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset asserted while in T2 of the first window.
        sb_en = 1'b0;
        load4();
        @(posedge clk); #1;
        mode = 1'b0; matrix = 6'd4; channels = 4'd1; memstartp = '0; memstartzap = 13'd100;
        maxp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t2_raddr", int'(mem_if.read_addressp), 4);
        rst_n = 1'b0;
        #1;
        check("arst_re", int'(mem_if.re), 0);
        check("arst_raddr", int'(mem_if.read_addressp), 0);
        check("arst_we", int'(mem_if.we), 0);
        check("arst_dp", int'(mem_if.dp), 0);
        check("arst_stop", int'(STOP), 0);
        maxp_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            cnt += int'(mem_if.re) + int'(mem_if.we);
        end
        check("idle_quiet", cnt, 0);
        exp_rd.delete();
        exp_wr.delete();
        sb_en = 1'b1;

        // Max, N=4, C=1.
        push_model(1'b0, 4, 1, 0, 100, 1000, 0);
        push_wr(100, 7); push_wr(101, 4); push_wr(102, 9); push_wr(103, 2);
        run(1'b0, 4, 1, 0, 100, cyc);
        check("max_cycles", cyc, 21);
        end_run();

        // Average, same data.
        push_model(1'b1, 4, 1, 0, 100, 1000, 0);
        push_wr(100, 3); push_wr(101, -2); push_wr(102, 2); push_wr(103, -2);
        run(1'b1, 4, 1, 0, 100, cyc);
        check("avg_cycles", cyc, 21);
        end_run();

        // Three channels of odd size 5.
        for (int i = 0; i < 75; i++) pmem[i] = 11'($urandom_range(0, 2047));
        push_model(1'b0, 5, 3, 0, 200, 1000, 1000);
        run(1'b0, 5, 3, 0, 200, cyc);
        check("multi_cycles", cyc, 61);
        end_run();
        push_model(1'b1, 5, 3, 0, 200, 1000, 1000);
        run(1'b1, 5, 3, 0, 200, cyc);
        check("multi_avg_cycles", cyc, 61);
        end_run();

        // Abort during T3 of the second window, then restart from window 0.
        load4();
        push_model(1'b0, 4, 1, 0, 100, 7, 1);
        @(posedge clk); #1;
        mode = 1'b0; matrix = 6'd4; channels = 4'd1; memstartp = '0; memstartzap = 13'd100;
        maxp_en = 1'b1;
        stop_seen = 1'b0;
        repeat (9) @(posedge clk);
        #1 maxp_en = 1'b0;
        check("abort_we", int'(mem_if.we), 0);
        @(posedge clk); #1;
        check("abort_re", int'(mem_if.re), 0);
        check("abort_stop", int'(STOP), 0);
        @(posedge clk); #1;
        check("abort_stop_seen", int'(stop_seen), 0);
        check("abort_rd_drain", exp_rd.size(), 0);
        check("abort_wr_drain", exp_wr.size(), 0);
        push_model(1'b0, 4, 1, 0, 100, 1000, 1000);
        run(1'b0, 4, 1, 0, 100, cyc);
        check("restart_cycles", cyc, 21);
        end_run();

        // Degenerate sizes finish at once with no memory traffic.
        run(1'b0, 1, 1, 0, 100, cyc);
        check("n1_cycles", cyc, 1);
        end_run();
        run(1'b1, 4, 0, 0, 100, cyc);
        check("c0_cycles", cyc, 1);
        end_run();

        // Single-window edge-value runs.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) pmem[300 + j] = 11'(tbl[i].v);
            push_model(tbl[i].m, 2, 1, 300, 400, 1000, 0);
            push_wr(400, tbl[i].exp);
            run(tbl[i].m, 2, 1, 300, 400, cyc);
            check("edge_cycles", cyc, 6);
            end_run();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
